// File: rtl/reg_file_sweep.sv
// rtl/reg_file_sweep.sv - parametrised 2R1W register file with hardware clear sweep
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module reg_file_sweep #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] DoutA,
  output logic [DATA_W-1:0] DoutB,
  input  logic              we,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] Din,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              wr_drop
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam bit                ZR        = (ZERO_REG != 0);
  localparam logic [ADDR_W:0]   NREGS_W   = (ADDR_W+1)'(NREGS);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] IDX_START = ZR ? ADDR_W'(1) : '0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic                wr_ok;

  // A write that would actually land in storage: legal address, not the hardwired zero.
  assign wr_ok = we && ({1'b0, rw} < NREGS_W) && !(ZR && (rw == '0));

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (({1'b0, a} < NREGS_W) && !(ZR && (a == '0))) begin
      v = regs_q[a];
`ifdef RF_BYPASS_EN
      if ((state_q == IDLE) && wr_ok && (a == rw)) v = Din;
`endif
    end
    return v;
  endfunction

  always_comb begin
    DoutA = rd_port(ra);
    DoutB = rd_port(rb);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if ((state_q == IDLE) && wr_ok && (rw == ADDR_W'(i)))
          regs_q[i] <= Din;
        else if ((state_q == CLEAR) && (idx_q == ADDR_W'(i)))
          regs_q[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = IDX_START;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        // Any core write offered mid-sweep is discarded and flagged.
        drop_d = we;
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr_busy = busy_q;
  assign wr_drop  = drop_q;

endmodule

// File: tb/tb_reg_file_sweep.sv
// tb/tb_reg_file_sweep.sv - scoreboard bench for reg_file_sweep (default parameters)
module tb_reg_file_sweep;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ra = '0, rb = '0, rw = '0;
  logic [31:0] Din = '0;
  logic        we = 1'b0, clr_req = 1'b0;
  logic [31:0] DoutA, DoutB;
  logic        clr_busy, wr_drop;

  reg_file_sweep dut (
    .clk(clk), .reset(reset), .ra(ra), .rb(rb), .DoutA(DoutA), .DoutB(DoutB),
    .we(we), .rw(rw), .Din(Din), .clr_req(clr_req), .clr_busy(clr_busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        drop;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: 32 words, reg 0 pinned to zero; a sweep is "cycles remaining" plus
  // the next word it will zero.
  int unsigned mem [32];
  int          sweep_left = 0;
  int          sweep_pos  = 0;
  bit          drop_m     = 1'b0;

  function automatic logic [31:0] m_read(input int addr);
    logic [31:0] v;
    v = (addr == 0) ? 32'd0 : mem[addr];
`ifdef RF_BYPASS_EN
    if (sweep_left == 0 && we && rw != 0 && addr != 0 && addr == int'(rw)) v = Din;
`endif
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mem[i] = 0;
    sweep_left = 0;
    sweep_pos  = 0;
    drop_m     = 1'b0;
  endtask

  task automatic m_edge();
    if (sweep_left == 0) begin
      if (we && rw != 0) mem[rw] = Din;
      drop_m = 1'b0;
      if (clr_req) begin
        sweep_left = 31;
        sweep_pos  = 1;
      end
    end else begin
      mem[sweep_pos] = 0;
      drop_m = we;
      sweep_pos++;
      sweep_left--;
    end
  endtask

  task automatic cyc(input logic r, input logic cq, input logic w, input logic [4:0] wa,
                     input logic [31:0] d, input logic [4:0] a, input logic [4:0] b);
    exp_t e;
    @(negedge clk);
    reset = r; clr_req = cq; we = w; rw = wa; Din = d; ra = a; rb = b;
    if (r) m_reset();
    #1;
    e.a    = m_read(int'(a));
    e.b    = m_read(int'(b));
    e.busy = (sweep_left != 0);
    e.drop = drop_m;
    exp_q.push_back(e);
    if (!r) m_edge();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("DoutA", DoutA, e.a);
        chk("DoutB", DoutB, e.b);
        chk("clr_busy", {31'd0, clr_busy}, {31'd0, e.busy});
        chk("wr_drop", {31'd0, wr_drop}, {31'd0, e.drop});
      end
    end
  end

  initial begin : driver
    int guard;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 5, 31);
    cyc(0, 0, 1, 5, 32'hDEADBEEF, 5, 31);
    cyc(0, 0, 1, 31, 32'h12345678, 5, 31);
    cyc(0, 0, 0, 0, 0, 5, 31);
    cyc(0, 0, 0, 0, 0, 0, 31);
    cyc(0, 0, 1, 0, 32'hFFFFFFFF, 0, 5);
    cyc(0, 0, 0, 0, 0, 0, 5);
    cyc(0, 0, 0, 0, 0, 0, 5);
    cyc(0, 0, 1, 9, 32'h55AA55AA, 9, 9);
    cyc(0, 0, 0, 0, 0, 9, 9);
    for (int i = 1; i < 32; i++) cyc(0, 0, 1, 5'(i), 32'(i), 5'(i), 5'(i - 1));
    cyc(0, 1, 0, 0, 0, 10, 11);
    for (int i = 0; i < 34; i++) begin
      if (i == 4) cyc(0, 0, 1, 7, 32'hAA, 7, 1);
      else if (i == 5 || i == 6) cyc(0, 1, 1, 5'(i), 32'hBEEF, 10, 11);
      else cyc(0, 0, 0, 0, 0, 10, 11);
    end
    for (int i = 0; i < 32; i += 2) cyc(0, 0, 0, 0, 0, 5'(i), 5'(i + 1));
    cyc(0, 0, 1, 3, 32'h33, 3, 3);
    cyc(0, 1, 1, 3, 32'h77, 3, 2);
    for (int i = 0; i < 33; i++) cyc(0, 0, 0, 0, 0, 3, 2);
    for (int i = 1; i < 32; i++) cyc(0, 0, 1, 5'(i), $urandom, 5'(i), 0);
    cyc(0, 1, 0, 0, 0, 20, 30);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 20, 30);
    cyc(1, 0, 0, 0, 0, 20, 30);
    cyc(0, 1, 0, 0, 0, 20, 30);
    cyc(0, 0, 0, 0, 0, 20, 30);
    for (int i = 0; i < 2500; i++) begin
      cyc(($urandom_range(0, 399) == 0), ($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1,
          5'($urandom), $urandom, 5'($urandom), 5'($urandom));
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
